if_fetch_stage: RTL
===================

// Module: if_fetch_stage
// PURPOSE
//  Instruction-fetch stage: owns the PC, issues single-outstanding requests to
//  instruction memory, and delivers each fetched instruction (with its PC) to
//  the IF/ID pipeline register via a write-enable pulse. Sits directly upstream
//  of IF/ID; honours downstream stall and branch/jump redirect from later stages.
// PARAMETERS
//  PC_W      16       PC / imem address width
//  INST_W    16       instruction width
//  RESET_PC  16'h0000 first fetch address after reset
//  PC_INC    2        PC increment per instruction (byte-addressed 16-bit insts)
// PORTS
//  clk          in   1       clock, all state on posedge
//  rst_n        in   1       asynchronous reset, active-low
//  imem_req     out  1       request strobe, one cycle per fetch
//  imem_addr    out  PC_W    fetch address, valid while imem_req=1
//  imem_ack     in   1       response valid; >=1 cycle after imem_req
//  imem_rdata   in   INST_W  instruction, valid with imem_ack
//  stall        in   1       IF/ID cannot accept this cycle
//  redirect     in   1       flush and restart fetch at redirect_pc
//  redirect_pc  in   PC_W    new fetch address
//  if_id_we     out  1       write enable to IF/ID (delivery this edge)
//  inst_out     out  INST_W  instruction delivered when if_id_we=1
//  pc_out       out  PC_W    PC of inst_out
// BEHAVIOUR
//  Reset (async, rst_n=0): state=START, pc=RESET_PC, hold_q=0; outputs
//   imem_req=0, if_id_we=0, inst_out=0, pc_out=RESET_PC. Released on next edge.
//  States: START, FETCH, WAIT, HOLD, DRAIN. imem_req=1 only in FETCH;
//   imem_addr=pc always. pc_out=pc always (pc advances only on delivery).
//  START: -> FETCH.
//  FETCH: issue request. redirect -> pc<=redirect_pc, DRAIN; else -> WAIT.
//  WAIT (outstanding request), priority order:
//   redirect & ack  -> discard data, pc<=redirect_pc, FETCH.
//   redirect & !ack -> pc<=redirect_pc, DRAIN.
//   ack & !stall    -> if_id_we=1, inst_out=imem_rdata (comb. same cycle),
//                      pc<=pc+PC_INC, FETCH.
//   ack & stall     -> hold_q<=imem_rdata, HOLD.
//   no ack          -> stay WAIT.
//  HOLD: inst_out=hold_q. redirect -> discard, pc<=redirect_pc, FETCH (redirect
//   beats stall). !stall -> if_id_we=1, pc<=pc+PC_INC, FETCH. else stay.
//  DRAIN: wait for ack of stale request, discard it, -> FETCH. redirect in
//   DRAIN updates pc, stays DRAIN. Never more than one outstanding request.
//  if_id_we=0 in START/FETCH/DRAIN and whenever redirect=1.
//  inst_out=hold_q whenever not delivering from WAIT.
//  PC arithmetic modulo 2^PC_W: 16'hFFFE + 2 wraps to 16'h0000.
//  Best-case throughput: one instruction per 2 cycles (ack 1 cycle after req).
//  imem_ack in START/FETCH/HOLD is a protocol error: ignored, flagged by assertion.
//  Reset mid-operation: immediate return to reset values; any outstanding
//   imem response arriving after reset release is ignored (START/FETCH).
// TESTING
//  Reset: hold rst_n=0 3 cycles -> imem_req=0, if_id_we=0, pc_out=0000;
//   release -> imem_req=1 with imem_addr=0000 on 2nd edge.
//  Straight line, ack 1-cycle latency, rdata=A000+addr: 4 deliveries with
//   pc_out 0000,0002,0004,0006, inst_out A000,A002,A004,A006, we every 2nd cycle.
//  Stall: stall=1 3 cycles across ack of addr 0004 -> no we, imem_req=0;
//   stall=0 -> single we with held inst A004, next req addr 0006.
//  Redirect in WAIT, ack 3 cycles late: redirect_pc=0100 -> stale ack dropped
//   (no we), next imem_addr=0100, delivered pc_out=0100.
//  Redirect in HOLD with stall=1: redirect_pc=0200 -> held inst dropped, no we,
//   next req 0200; wrap case RESET_PC=FFFE delivers FFFE then 0000.
//  Reset asserted in WAIT, ack arrives after release -> ignored, first we has
//   pc_out=RESET_PC.

Source files
------------

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, keeps at most one instruction-memory
// request in flight and hands each fetched instruction with its PC to IF/ID.
`timescale 1ns/1ps

module if_fetch_stage #(
  parameter int unsigned     PC_W     = 16,
  parameter int unsigned     INST_W   = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int unsigned     PC_INC   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_ack,
  input  logic [INST_W-1:0] imem_rdata,
  input  logic              stall,
  input  logic              redirect,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic              if_id_we,
  output logic [INST_W-1:0] inst_out,
  output logic [PC_W-1:0]   pc_out
);

  typedef enum logic [2:0] {
    S_START,
    S_FETCH,
    S_WAIT,
    S_HOLD,
    S_DRAIN
  } state_t;

  state_t              state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [PC_W-1:0]     pcNext;
  logic [INST_W-1:0]   hold_q, hold_d;
  logic                bootWindow_q, bootWindow_d;

  assign pcNext    = pc_q + PC_W'(PC_INC);
  assign imem_addr = pc_q;
  assign pc_out    = pc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_START;
      pc_q         <= RESET_PC;
      hold_q       <= '0;
      bootWindow_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      hold_q       <= hold_d;
      bootWindow_q <= bootWindow_d;
    end
  end

  // A response that was in flight when reset hit may still land in the first
  // START/FETCH after release; it is ignored, and the window marks it legal.
  assign bootWindow_d = bootWindow_q & ((state_q == S_START) | (state_q == S_FETCH));

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    hold_d   = hold_q;
    imem_req = 1'b0;
    if_id_we = 1'b0;
    inst_out = hold_q;

    case (state_q)
      S_START: begin
        state_d = S_FETCH;
      end

      S_FETCH: begin
        imem_req = 1'b1;
        if (redirect) begin
          pc_d    = redirect_pc;
          state_d = S_DRAIN;
        end else begin
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (redirect && imem_ack) begin
          pc_d    = redirect_pc;
          state_d = S_FETCH;
        end else if (redirect) begin
          pc_d    = redirect_pc;
          state_d = S_DRAIN;
        end else if (imem_ack && !stall) begin
          if_id_we = 1'b1;
          inst_out = imem_rdata;
          pc_d     = pcNext;
          state_d  = S_FETCH;
        end else if (imem_ack) begin
          hold_d  = imem_rdata;
          state_d = S_HOLD;
        end
      end

      S_HOLD: begin
        if (redirect) begin
          pc_d    = redirect_pc;
          state_d = S_FETCH;
        end else if (!stall) begin
          if_id_we = 1'b1;
          pc_d     = pcNext;
          state_d  = S_FETCH;
        end
      end

      S_DRAIN: begin
        // The stale response retires the old request even if a new redirect
        // arrives in the same cycle, otherwise we would wait forever.
        if (redirect) begin
          pc_d = redirect_pc;
        end
        if (imem_ack) begin
          state_d = S_FETCH;
        end
      end

      default: begin
        state_d = S_START;
      end
    endcase
  end

  property pNoUnexpectedAck;
    @(posedge clk) disable iff (!rst_n)
      imem_ack |-> ((state_q == S_WAIT) || (state_q == S_DRAIN) ||
                    (bootWindow_q && (state_q != S_HOLD)));
  endproperty

  assert property (pNoUnexpectedAck);

endmodule
